// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states and pipeline stall (optional DMEM_MISALIGN_TRAP_EN)
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic          byte_q, byte_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH];
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_word;
    logic [7:0]    rd_lane;
    logic [31:0]   merged_word;
    logic          misalign;

    // Upper address bits fall outside the array; addresses wrap modulo DEPTH*4.
    logic          addr_unused;
    assign addr_unused = ^addr[31:AW+2];

    assign rd_word = mem_q[idx_q];

    // Lane extraction and byte-store merge for the latched request.
    always_comb begin
        rd_lane     = rd_word[7:0];
        merged_word = rd_word;
        case (lane_q)
            2'd0: begin
                rd_lane           = rd_word[7:0];
                merged_word[7:0]  = wdata_q[7:0];
            end
            2'd1: begin
                rd_lane           = rd_word[15:8];
                merged_word[15:8] = wdata_q[7:0];
            end
            2'd2: begin
                rd_lane            = rd_word[23:16];
                merged_word[23:16] = wdata_q[7:0];
            end
            default: begin
                rd_lane            = rd_word[31:24];
                merged_word[31:24] = wdata_q[7:0];
            end
        endcase
    end

    // Misaligned word accesses are only trapped when the feature is built in;
    // otherwise the low address bits are simply dropped for word accesses.
    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = !byte_q && (lane_q != 2'd0);
`else
        misalign = 1'b0;
`endif
    end

    // Next-state logic: capture in IDLE, count wait states, perform the access on the last one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        byte_d       = byte_q;
        idx_d        = idx_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    byte_d  = req_byte;
                    idx_d   = addr[AW+1:2];
                    lane_d  = addr[1:0];
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    if (misalign) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else if (write_q) begin
                        mem_we    = 1'b1;
                        mem_wdata = byte_q ? merged_word : wdata_q;
                    end else begin
                        rdata_d = byte_q ? {24'd0, rd_lane} : rd_word;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            idx_q        <= '0;
            lane_q       <= 2'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
        end
    end

    // Array write port; contents are never cleared and a reset blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    assign rdata      = rdata_q;
    assign resp_valid = resp_valid_q;
    assign stall      = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = err_q;
`else
    logic err_unused;
    assign err_unused = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a word-array model
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_byte;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        stall;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .AW(10), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .stall      (stall)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .err        (err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;

    // Reference: whole-word array, lanes handled with shifts and masks.
    task automatic model_access(input logic w, input logic b, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] exp_rdata);
        int idx;
        int sh;
        bit misal;
        idx   = int'((a / 4) % DEPTH);
        sh    = 8 * int'(a % 4);
        misal = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = !b && (a % 4 != 0);
`endif
        if (misal)
            ref_rdata = 32'd0;
        else if (w && b)
            ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        else if (w)
            ref_mem[idx] = d;
        else if (b)
            ref_rdata = (ref_mem[idx] >> sh) & 32'hFF;
        else
            ref_rdata = ref_mem[idx];
        exp_rdata = ref_rdata;
    endtask

    int cyc_cnt = 0;
    int pulses  = 0;
    int last_resp_cyc = 0;

    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) if (resp_valid === 1'b1) pulses++;

    // One access: checks stall every busy cycle, latency, rdata and err at the response.
    task automatic access(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, input bit keep);
        logic [31:0] er;
        int n;
        bit done;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        addr      = a;
        wdata     = d;
        model_access(w, b, a, d, er);
        n    = 0;
        done = 1'b0;
        while (!done) begin
            #1;
            if (resp_valid === 1'b1) begin
                done = 1'b1;
                check("latency", 32'(n), 32'(LAT + 1));
                check("stall_resp", 32'(stall), 32'd0);
                check("rdata", rdata, er);
`ifdef DMEM_MISALIGN_TRAP_EN
                check("err", 32'(err), 32'(!b && (a[1:0] != 2'd0)));
`endif
                last_resp_cyc = cyc_cnt;
            end else begin
                check("stall_busy", 32'(stall), 32'd1);
                if (n >= 40) begin
                    check("resp_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
        end
        if (!keep) req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int r1;
        bit keep;
        logic [31:0] a;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        ref_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rdata", rdata, 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("reset_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Word store then load.
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("plan_word", rdata, 32'hDEADBEEF);

        // Byte lanes.
        access(1'b1, 1'b0, 32'h20, 32'h11223344, 1'b0);
        access(1'b1, 1'b1, 32'h22, 32'h000000AA, 1'b0);
        access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        check("plan_byte_merge", rdata, 32'h11AA3344);
        access(1'b0, 1'b1, 32'h23, 32'h0, 1'b0);
        check("plan_byte_load", rdata, 32'h00000011);

        // Address wrap.
        access(1'b1, 1'b0, 32'h1000, 32'h5, 1'b0);
        access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("plan_wrap", rdata, 32'h5);

        // Misaligned word store.
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h31, 32'h12345678, 1'b0);
        access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("plan_misalign", rdata, 32'h0);
`else
        check("plan_misalign", rdata, 32'h12345678);
`endif

        // Reset in the first WAIT cycle abandons the store.
        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        addr      = 32'h40;
        wdata     = 32'hCAFEF00D;
        p0 = pulses;
        @(negedge clk);
        #1;
        check("rst_mid_stall_wait", 32'(stall), 32'd1);
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_resp", 32'(resp_valid), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        ref_rdata = 32'd0;
        repeat (4) @(negedge clk);
        check("rst_mid_no_pulse", 32'(pulses), 32'(p0));
        access(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        check("rst_mid_mem", rdata, 32'h0);

        // Back-to-back loads with req_valid held high.
        access(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
        r1 = last_resp_cyc;
        p0 = pulses;
        access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        check("b2b_sep", 32'(last_resp_cyc - r1), 32'(LAT + 2));
        @(negedge clk);
        check("b2b_pulses", 32'(pulses), 32'(p0 + 1));

        // Randomized traffic over a 16-word window with aliased upper bits.
        for (int i = 0; i < 16; i++)
            access(1'b1, 1'b0, 32'h100 + 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 7) << 12) | 32'h100 | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            keep = ($urandom_range(0, 1) == 1);
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
